// File: rtl/operand_entry.sv
// operand_entry: keypad operand-entry block for the stopwatch-calculator.
// Debounces the raw key-down level, decodes each accepted key and assembles
// two unsigned decimal operands of up to DIGITS digits each.
//
// Optional feature macro: OPERAND_NEG_EN (per-operand sign, toggled by key 11).
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   number   key code from the keypad decoder (sampled on the accepting edge)
//   pressed  raw key-down level, may bounce
//   in1/in2  operand values (two's complement when negated and OPERAND_NEG_EN)
//   led1/2   operand explicitly selected
//   dcnt1/2  digits held in each operand
//   full     active operand holds DIGITS digits (combinational)
//   key_ack  one-cycle pulse in the cycle after each accepted key
module operand_entry #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   number,
  input  logic                         pressed,
  output logic [WIDTH-1:0]             in1,
  output logic [WIDTH-1:0]             in2,
  output logic                         led1,
  output logic                         led2,
  output logic [$clog2(DIGITS+1)-1:0]  dcnt1,
  output logic [$clog2(DIGITS+1)-1:0]  dcnt2,
  output logic                         full,
  output logic                         key_ack
);

  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);

  typedef enum logic {
    EDIT1 = 1'b0,
    EDIT2 = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mag1_q, mag1_d, mag2_q, mag2_d;
  logic [CW-1:0]    cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic             led1_q, led1_d, led2_q, led2_d;
  logic             key_ack_q, key_ack_d;
  logic [DW-1:0]    db_cnt_q, db_cnt_d;
  // Blocks acceptance after a reset taken while the key was held down.
  logic             lock_q, lock_d;
`ifdef OPERAND_NEG_EN
  logic             neg1_q, neg1_d, neg2_q, neg2_d;
  logic             act_neg, new_neg;
`endif

  logic             accept_c;
  logic [WIDTH-1:0] act_mag, new_mag;
  logic [CW-1:0]    act_cnt, new_cnt;

  // State register, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EDIT1;
      mag1_q    <= '0;
      mag2_q    <= '0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
      led1_q    <= 1'b0;
      led2_q    <= 1'b0;
      key_ack_q <= 1'b0;
      db_cnt_q  <= '0;
      lock_q    <= pressed;
`ifdef OPERAND_NEG_EN
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mag1_q    <= mag1_d;
      mag2_q    <= mag2_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      led1_q    <= led1_d;
      led2_q    <= led2_d;
      key_ack_q <= key_ack_d;
      db_cnt_q  <= db_cnt_d;
      lock_q    <= lock_d;
`ifdef OPERAND_NEG_EN
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
`endif
    end
  end

  // Debounce, key decode and next-state logic
  always_comb begin
    state_d   = state_q;
    mag1_d    = mag1_q;
    mag2_d    = mag2_q;
    cnt1_d    = cnt1_q;
    cnt2_d    = cnt2_q;
    led1_d    = led1_q;
    led2_d    = led2_q;
    key_ack_d = 1'b0;
    db_cnt_d  = db_cnt_q;
    lock_d    = lock_q;
`ifdef OPERAND_NEG_EN
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    act_neg   = (state_q == EDIT1) ? neg1_q : neg2_q;
    new_neg   = act_neg;
`endif
    act_mag   = (state_q == EDIT1) ? mag1_q : mag2_q;
    act_cnt   = (state_q == EDIT1) ? cnt1_q : cnt2_q;
    new_mag   = act_mag;
    new_cnt   = act_cnt;

    // Acceptance happens exactly on the DEBOUNCE-1 -> DEBOUNCE step.
    accept_c = pressed && !lock_q && (db_cnt_q == DW'(DEBOUNCE - 1));

    if (!pressed) begin
      db_cnt_d = '0;
      lock_d   = 1'b0;
    end else if (!lock_q && (db_cnt_q != DW'(DEBOUNCE))) begin
      db_cnt_d = db_cnt_q + DW'(1);
    end

    if (accept_c) begin
      key_ack_d = 1'b1;
      case (number)
        4'd12: begin
          if (act_cnt != '0) begin
            new_mag = act_mag / WIDTH'(10);
            new_cnt = act_cnt - CW'(1);
          end
        end
        4'd13: begin
          new_mag = '0;
          new_cnt = '0;
`ifdef OPERAND_NEG_EN
          new_neg = 1'b0;
`endif
        end
        4'd14: begin
          state_d = EDIT2;
          mag2_d  = '0;
          cnt2_d  = '0;
          led1_d  = 1'b0;
          led2_d  = 1'b1;
`ifdef OPERAND_NEG_EN
          neg2_d  = 1'b0;
`endif
        end
        4'd15: begin
          state_d = EDIT1;
          mag1_d  = '0;
          cnt1_d  = '0;
          led1_d  = 1'b1;
          led2_d  = 1'b0;
`ifdef OPERAND_NEG_EN
          neg1_d  = 1'b0;
`endif
        end
`ifdef OPERAND_NEG_EN
        4'd11: new_neg = ~act_neg;
`endif
        default: begin
          // Digits shift in from the right; a full operand ignores them.
          if ((number <= 4'd9) && (act_cnt < CW'(DIGITS))) begin
            new_mag = (act_mag * WIDTH'(10)) + WIDTH'(number);
            new_cnt = act_cnt + CW'(1);
          end
        end
      endcase

      // Edit keys only ever touch the active operand.
      if (number < 4'd14) begin
        if (state_q == EDIT1) begin
          mag1_d = new_mag;
          cnt1_d = new_cnt;
`ifdef OPERAND_NEG_EN
          neg1_d = new_neg;
`endif
        end else begin
          mag2_d = new_mag;
          cnt2_d = new_cnt;
`ifdef OPERAND_NEG_EN
          neg2_d = new_neg;
`endif
        end
      end
    end
  end

`ifdef OPERAND_NEG_EN
  assign in1 = neg1_q ? (WIDTH'(0) - mag1_q) : mag1_q;
  assign in2 = neg2_q ? (WIDTH'(0) - mag2_q) : mag2_q;
`else
  assign in1 = mag1_q;
  assign in2 = mag2_q;
`endif
  assign led1    = led1_q;
  assign led2    = led2_q;
  assign dcnt1   = cnt1_q;
  assign dcnt2   = cnt2_q;
  assign key_ack = key_ack_q;
  assign full    = (((state_q == EDIT1) ? cnt1_q : cnt2_q) == CW'(DIGITS));

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- Parametrised keypad operand-entry block for the stopwatch-calculator; sits between the keypad decoder and the arithmetic unit.
- Debounces a key-press strobe in the clock domain and decodes each accepted key.
- Assembles two unsigned decimal operands of up to DIGITS digits each, with backspace, clear and operand-select keys.
- Presents operands, selection LEDs and per-operand digit counts to downstream logic.

Parameters:
- WIDTH, 32, operand register width; must hold 10^DIGITS-1 (plus sign bit when OPERAND_NEG_EN is defined).
- DIGITS, 2, maximum decimal digits per operand.
- DEBOUNCE, 3, consecutive high samples of pressed needed to accept a key; minimum 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- number  in  4  key code from decoder
- pressed  in  1  raw key-down level, may bounce
- in1  out  WIDTH  operand 1 value
- in2  out  WIDTH  operand 2 value
- led1  out  1  operand 1 explicitly selected
- led2  out  1  operand 2 explicitly selected
- dcnt1  out  $clog2(DIGITS+1)  digits held in operand 1
- dcnt2  out  $clog2(DIGITS+1)  digits held in operand 2
- full  out  1  active operand holds DIGITS digits
- key_ack  out  1  one-cycle pulse, cycle after each accepted key

Behaviour:
- Reset (rst high at clk edge): in1=in2=0, dcnt1=dcnt2=0, led1=led2=0, key_ack=0, active operand=1, debounce counter=0. Reset overrides any key in the same cycle. Reset mid-press: the key is not accepted until pressed is sampled low and then re-qualified.
- Debounce:
  - Counter cleared on any edge with pressed=0.
  - Increments while pressed=1, saturating at DEBOUNCE.
  - Key accepted on the edge where the counter goes DEBOUNCE-1 -> DEBOUNCE; number is sampled on that same edge.
  - Exactly one acceptance per press. The next acceptance requires at least one low sample.
- Update timing: operand/LED/count registers update on the accepting edge; key_ack is high for the following cycle only.
- Key decode (applies to the active operand A with count C):
  - 0-9, digit: if C<DIGITS then A<=A*10+number (shift-add, truncated to WIDTH), C<=C+1; else ignored (no change), key_ack still pulses.
  - 12, backspace: if C>0 then A<=A/10, C<=C-1; if C=0 no change.
  - 13, clear active: A<=0, C<=0; selection and LEDs unchanged.
  - 14, select operand 2: active<=2, in2<=0, dcnt2<=0, led1<=0, led2<=1.
  - 15, select operand 1: active<=1, in1<=0, dcnt1<=0, led1<=1, led2<=0.
  - 10, 11: ignored (11 reserved for OPERAND_NEG_EN).
- full is combinational from the active operand's count: (C==DIGITS).
- Select of the already-active operand still clears it.
- The inactive operand is never modified by digit, backspace or clear keys.
- State is two-valued: EDIT1 (reset state) and EDIT2. Key 14 moves to EDIT2, key 15 moves to EDIT1, from either state.

Optional Feature:
- Macro OPERAND_NEG_EN.
- Defined:
  - Per-operand sign bit, cleared by reset, select and clear.
  - Key 11 toggles the active operand's sign, allowed at any count, including 0.
  - in1/in2 output two's complement of the magnitude when the sign is set.
  - Digit and backspace keys operate on the magnitude.
- Not defined: key 11 ignored; outputs are unsigned magnitudes.

Test Plan:
- rst, then pressed high 3 cycles with number=4 -> in1=4, dcnt1=1, key_ack pulses once; holding pressed 20 more cycles -> no further change.
- pressed bouncing 1,0,1,1,0 with number=7 -> no acceptance; then 3 clean high cycles -> in1=7.
- Keys 15,1,2,3 (DIGITS=2) -> led1=1, in1=12, full=1 after key 2; key 3 ignored, key_ack still pulses.
- Keys 15,5,6, 14,9, 12, 8 -> in1=56 unchanged, in2=8, dcnt2=1, led2=1, led1=0.
- Keys 15,4,2, 12, 12, 12 -> in1 4 then 0, dcnt1 0; third backspace no change; key 13 after digit 9 -> in1=0.
- With OPERAND_NEG_EN: keys 15,2,5,11 -> in1=-25 (32'hFFFFFFE7); key 11 again -> 25; rst asserted during the next press -> in1=0, no acceptance until pressed is sampled low.
